// File: rtl/router_route_stage_pkg.sv
// Shared types for the mesh router input stage: direction codes,
// routing mode selector and the per-port packet FSM states.
package router_pkg;

  typedef enum logic [3:0] {
    LOCAL = 4'd0,
    NORTH = 4'd1,
    SOUTH = 4'd2,
    EAST  = 4'd3,
    WEST  = 4'd4,
    NE    = 4'd5,
    NW    = 4'd6,
    SE    = 4'd7,
    SW    = 4'd8
  } dir_e;

  typedef enum logic {
    ROUTE_XY   = 1'b0,
    ROUTE_DIAG = 1'b1
  } route_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } route_state_e;

endpackage

// File: rtl/router_route_stage_if.sv
// Flit handshake bundle between upstream link, route stage and switch allocator.
interface router_route_stage_if #(
  parameter int unsigned DW = 32
) ();

  logic                 in_valid_i;
  logic                 in_ready_o;
  logic                 in_head_i;
  logic                 in_tail_i;
  logic [DW-1:0]        in_data_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic                 out_head_o;
  logic                 out_tail_o;
  logic [DW-1:0]        out_data_o;
  router_pkg::dir_e     out_dir_o;

  // Upstream/downstream side (drives flits in, takes flits out)
  modport master (
    output in_valid_i, in_head_i, in_tail_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_head_o, out_tail_o, out_data_o, out_dir_o
  );

  // Route stage side
  modport slave (
    input  in_valid_i, in_head_i, in_tail_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_head_o, out_tail_o, out_data_o, out_dir_o
  );

endinterface

// File: rtl/router_route_stage_calc.sv
// Combinational route computation from a head flit's destination coordinates.
module router_route_calc
  import router_pkg::*;
#(
  parameter int unsigned XW    = 2,
  parameter int unsigned YW    = 2,
  parameter int unsigned SELFX = 2,
  parameter int unsigned SELFY = 2,
  parameter route_mode_e MODE  = ROUTE_XY
) (
  input  logic [XW-1:0] dst_x_i,
  input  logic [YW-1:0] dst_y_i,
  output dir_e          dir_o
);

  localparam logic [XW-1:0] SX = XW'(SELFX);
  localparam logic [YW-1:0] SY = YW'(SELFY);

  logic east, west, north, south;

  // Per-axis unsigned comparison, then mode-dependent direction select
  always_comb begin
    east  = dst_x_i > SX;
    west  = dst_x_i < SX;
    north = dst_y_i > SY;
    south = dst_y_i < SY;
    dir_o = LOCAL;
    if (MODE == ROUTE_DIAG && (east || west) && (north || south)) begin
      if (north) dir_o = east ? NE : NW;
      else       dir_o = east ? SE : SW;
    end else if (east) begin
      dir_o = EAST;
    end else if (west) begin
      dir_o = WEST;
    end else if (north) begin
      dir_o = NORTH;
    end else if (south) begin
      dir_o = SOUTH;
    end
  end

endmodule

// File: rtl/router_route_stage.sv
// Router input-port stage: per-packet route lock, flit FIFO tagged with
// direction, protocol error detection and packet/error counters.
module router_route_stage
  import router_pkg::*;
#(
  parameter int unsigned XW    = 2,
  parameter int unsigned YW    = 2,
  parameter int unsigned SELFX = 2,
  parameter int unsigned SELFY = 2,
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 4,
  parameter route_mode_e MODE  = ROUTE_XY
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  router_route_stage_if.slave  bus,
  output logic                 err_o,
  output logic [15:0]          pkt_cnt_o,
  output logic [7:0]           err_cnt_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0]  data_mem_q [DEPTH];
  logic           head_mem_q [DEPTH];
  logic           tail_mem_q [DEPTH];
  dir_e           dir_mem_q  [DEPTH];

  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  route_state_e   state_q, state_d;
  dir_e           cur_dir_q, cur_dir_d;
  logic           err_q, err_d;
  logic [15:0]    pkt_cnt_q, pkt_cnt_d;
  logic [7:0]     err_cnt_q, err_cnt_d;

  logic           full, empty, accept, pop, push, head_acc;
  dir_e           route_dir, push_dir;

  router_route_calc #(
    .XW    (XW),
    .YW    (YW),
    .SELFX (SELFX),
    .SELFY (SELFY),
    .MODE  (MODE)
  ) u_calc (
    .dst_x_i (bus.in_data_i[XW-1:0]),
    .dst_y_i (bus.in_data_i[XW+YW-1:XW]),
    .dir_o   (route_dir)
  );

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  // Ready is forced low while reset is held so nothing is taken mid-flush
  assign bus.in_ready_o = !rst_i && !full;
  assign accept = bus.in_valid_i && bus.in_ready_o;
  assign pop    = !empty && bus.out_ready_i;

  assign bus.out_valid_o = !empty;
  assign bus.out_data_o  = data_mem_q[rd_ptr_q];
  assign bus.out_head_o  = head_mem_q[rd_ptr_q];
  assign bus.out_tail_o  = tail_mem_q[rd_ptr_q];
  assign bus.out_dir_o   = dir_mem_q[rd_ptr_q];

  assign err_o     = err_q;
  assign pkt_cnt_o = pkt_cnt_q;
  assign err_cnt_o = err_cnt_q;

  // Packet FSM: route lock on head, error classification, push decision
  always_comb begin
    state_d   = state_q;
    cur_dir_d = cur_dir_q;
    push      = 1'b0;
    push_dir  = cur_dir_q;
    err_d     = 1'b0;
    head_acc  = 1'b0;
    if (accept) begin
      if (bus.in_head_i) begin
        // A head in PKT restarts the packet exactly as a head in IDLE would
        push      = 1'b1;
        push_dir  = route_dir;
        cur_dir_d = route_dir;
        head_acc  = 1'b1;
        err_d     = (state_q == ST_PKT);
        state_d   = bus.in_tail_i ? ST_IDLE : ST_PKT;
      end else if (state_q == ST_IDLE) begin
        err_d = 1'b1;
      end else begin
        push = 1'b1;
        if (bus.in_tail_i) state_d = ST_IDLE;
      end
    end
  end

  // Pointer, occupancy and counter next-state
  always_comb begin
    count_d   = count_q + CW'(push) - CW'(pop);
    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    pkt_cnt_d = head_acc ? pkt_cnt_q + 16'd1 : pkt_cnt_q;
    err_cnt_d = (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  // Control state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cur_dir_q <= LOCAL;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cur_dir_q <= cur_dir_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_q     <= err_d;
      pkt_cnt_q <= pkt_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // FIFO storage; cleared on reset so idle outputs read as zero
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        data_mem_q[k] <= '0;
        head_mem_q[k] <= 1'b0;
        tail_mem_q[k] <= 1'b0;
        dir_mem_q[k]  <= LOCAL;
      end
    end else if (push) begin
      data_mem_q[wr_ptr_q] <= bus.in_data_i;
      head_mem_q[wr_ptr_q] <= bus.in_head_i;
      tail_mem_q[wr_ptr_q] <= bus.in_tail_i;
      dir_mem_q[wr_ptr_q]  <= push_dir;
    end
  end

endmodule

// File: tb/tb_router_route_stage.sv
// Directed bench for router_route_stage: XY and DIAG instances, scoreboard
// queues filled at send time and drained by per-instance output monitors.
module tb_router_route_stage;
  import router_pkg::*;

  typedef struct packed {
    logic        head;
    logic        tail;
    logic [31:0] data;
    dir_e        dir;
  } flit_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        x_err, d_err;
  logic [15:0] x_pkt, d_pkt;
  logic [7:0]  x_ecnt, d_ecnt;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned xpops  = 0;
  int unsigned p0;
  logic [31:0] held;
  flit_t       xq[$], dq[$];
  flit_t       xe, xo, de, dob;

  router_route_stage_if #(.DW(32)) xif ();
  router_route_stage_if #(.DW(32)) dif ();

  always #5 clk = ~clk;

  router_route_stage #(
    .XW(2), .YW(2), .SELFX(2), .SELFY(2), .DW(32), .DEPTH(4), .MODE(ROUTE_XY)
  ) u_xy (
    .clk_i(clk), .rst_i(rst), .bus(xif.slave),
    .err_o(x_err), .pkt_cnt_o(x_pkt), .err_cnt_o(x_ecnt)
  );

  router_route_stage #(
    .XW(2), .YW(2), .SELFX(2), .SELFY(2), .DW(32), .DEPTH(4), .MODE(ROUTE_DIAG)
  ) u_dg (
    .clk_i(clk), .rst_i(rst), .bus(dif.slave),
    .err_o(d_err), .pkt_cnt_o(d_pkt), .err_cnt_o(d_ecnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int unsigned x, input int unsigned y, input logic [7:0] tag);
    mk = {20'h0, tag, 2'(y), 2'(x)};
  endfunction

  task automatic send(input bit dg, input logic h, input logic t, input logic [31:0] d,
                      input bit push, input dir_e dir);
    int unsigned n;
    logic        rdy;
    flit_t       f;
    n = 0;
    @(negedge clk);
    if (dg) begin
      dif.in_valid_i = 1'b1; dif.in_head_i = h; dif.in_tail_i = t; dif.in_data_i = d;
    end else begin
      xif.in_valid_i = 1'b1; xif.in_head_i = h; xif.in_tail_i = t; xif.in_data_i = d;
    end
    rdy = dg ? dif.in_ready_o : xif.in_ready_o;
    while (!rdy && n < 50) begin
      @(negedge clk);
      n++;
      rdy = dg ? dif.in_ready_o : xif.in_ready_o;
    end
    chk("send_ready", 64'(rdy), 64'(1));
    f.head = h; f.tail = t; f.data = d; f.dir = dir;
    if (push) begin
      if (dg) dq.push_back(f);
      else    xq.push_back(f);
    end
    @(posedge clk);
    #1;
    if (dg) dif.in_valid_i = 1'b0;
    else    xif.in_valid_i = 1'b0;
  endtask

  // XY output monitor: compare every departing flit against the scoreboard
  always @(negedge clk) begin
    if (!rst && xif.out_valid_o && xif.out_ready_i) begin
      chk("x_sb_nonempty", 64'(xq.size() > 0), 64'(1));
      if (xq.size() > 0) begin
        xe = xq.pop_front();
        xo.head = xif.out_head_o; xo.tail = xif.out_tail_o;
        xo.data = xif.out_data_o; xo.dir  = xif.out_dir_o;
        chk("x_flit", 64'(xo), 64'(xe));
      end
      xpops++;
    end
  end

  // DIAG output monitor
  always @(negedge clk) begin
    if (!rst && dif.out_valid_o && dif.out_ready_i) begin
      chk("d_sb_nonempty", 64'(dq.size() > 0), 64'(1));
      if (dq.size() > 0) begin
        de = dq.pop_front();
        dob.head = dif.out_head_o; dob.tail = dif.out_tail_o;
        dob.data = dif.out_data_o; dob.dir  = dif.out_dir_o;
        chk("d_flit", 64'(dob), 64'(de));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    xif.in_valid_i = 1'b0; xif.in_head_i = 1'b0; xif.in_tail_i = 1'b0;
    xif.in_data_i = '0; xif.out_ready_i = 1'b1;
    dif.in_valid_i = 1'b0; dif.in_head_i = 1'b0; dif.in_tail_i = 1'b0;
    dif.in_data_i = '0; dif.out_ready_i = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  64'(xif.in_ready_o),  64'(0));
    chk("rst_out_valid", 64'(xif.out_valid_o), 64'(0));
    chk("rst_err",       64'(x_err),           64'(0));
    chk("rst_pkt_cnt",   64'(x_pkt),           64'(0));
    chk("rst_err_cnt",   64'(x_ecnt),          64'(0));
    chk("rst_out_data",  64'(xif.out_data_o),  64'(0));
    chk("rst_out_flags", 64'({xif.out_head_o, xif.out_tail_o}), 64'(0));
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(xif.in_ready_o), 64'(1));

    // XY single-flit packets
    send(1'b0, 1'b1, 1'b1, mk(2, 2, 8'h01), 1'b1, LOCAL);
    chk("latency_valid", 64'(xif.out_valid_o), 64'(1));
    send(1'b0, 1'b1, 1'b1, mk(3, 1, 8'h02), 1'b1, EAST);
    send(1'b0, 1'b1, 1'b1, mk(2, 0, 8'h03), 1'b1, SOUTH);
    chk("xy_pkt_cnt3", 64'(x_pkt), 64'(3));

    // DIAG single-flit packets
    send(1'b1, 1'b1, 1'b1, mk(3, 3, 8'h11), 1'b1, NE);
    send(1'b1, 1'b1, 1'b1, mk(0, 1, 8'h12), 1'b1, SW);
    send(1'b1, 1'b1, 1'b1, mk(2, 3, 8'h13), 1'b1, NORTH);
    send(1'b1, 1'b1, 1'b1, mk(1, 2, 8'h14), 1'b1, WEST);
    chk("dg_pkt_cnt4", 64'(d_pkt), 64'(4));

    // Multi-flit packet: body payloads would route EAST if recomputed
    send(1'b0, 1'b1, 1'b0, mk(0, 2, 8'h21), 1'b1, WEST);
    send(1'b0, 1'b0, 1'b0, mk(3, 3, 8'h22), 1'b1, WEST);
    send(1'b0, 1'b0, 1'b0, mk(3, 0, 8'h23), 1'b1, WEST);
    send(1'b0, 1'b0, 1'b1, mk(3, 3, 8'h24), 1'b1, WEST);
    send(1'b0, 1'b1, 1'b1, mk(3, 2, 8'h25), 1'b1, EAST);
    repeat (3) @(posedge clk);
    #1;
    chk("multi_drained", 64'(xq.size()), 64'(0));

    // Backpressure: fill to DEPTH, then release and drain one per cycle
    xif.out_ready_i = 1'b0;
    send(1'b0, 1'b1, 1'b1, mk(3, 0, 8'h31), 1'b1, EAST);
    send(1'b0, 1'b1, 1'b1, mk(0, 3, 8'h32), 1'b1, WEST);
    send(1'b0, 1'b1, 1'b1, mk(2, 3, 8'h33), 1'b1, NORTH);
    send(1'b0, 1'b1, 1'b1, mk(1, 1, 8'h34), 1'b1, WEST);
    chk("full_ready_low", 64'(xif.in_ready_o),  64'(0));
    chk("full_valid",     64'(xif.out_valid_o), 64'(1));
    held = mk(3, 0, 8'h31);
    chk("stall_head_data", 64'(xif.out_data_o), 64'(held));
    @(posedge clk); #1;
    chk("stall_stable", 64'(xif.out_data_o), 64'(held));
    chk("stall_still_full", 64'(xif.in_ready_o), 64'(0));
    p0 = xpops;
    xif.out_ready_i = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    chk("drain_rate",  64'(xpops - p0),       64'(4));
    chk("drain_empty", 64'(xif.out_valid_o),  64'(0));

    // Protocol errors
    send(1'b0, 1'b0, 1'b0, mk(1, 1, 8'h41), 1'b0, LOCAL);
    chk("idle_body_err",     64'(x_err),  64'(1));
    chk("idle_body_err_cnt", 64'(x_ecnt), 64'(1));
    @(posedge clk); #1;
    chk("err_pulse_end", 64'(x_err), 64'(0));
    chk("idle_body_dropped", 64'(xif.out_valid_o), 64'(0));
    send(1'b0, 1'b1, 1'b0, mk(0, 2, 8'h42), 1'b1, WEST);
    chk("head_no_err", 64'(x_err), 64'(0));
    send(1'b0, 1'b1, 1'b0, mk(3, 2, 8'h43), 1'b1, EAST);
    chk("pkt_head_err",     64'(x_err),  64'(1));
    chk("pkt_head_err_cnt", 64'(x_ecnt), 64'(2));
    send(1'b0, 1'b0, 1'b1, mk(0, 0, 8'h44), 1'b1, EAST);
    chk("xy_pkt_cnt11", 64'(x_pkt), 64'(11));
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-packet with three flits queued
    xif.out_ready_i = 1'b0;
    send(1'b0, 1'b1, 1'b0, mk(0, 2, 8'h51), 1'b1, WEST);
    send(1'b0, 1'b0, 1'b0, mk(0, 2, 8'h52), 1'b1, WEST);
    send(1'b0, 1'b0, 1'b0, mk(0, 2, 8'h53), 1'b1, WEST);
    chk("pre_rst_valid", 64'(xif.out_valid_o), 64'(1));
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    xq.delete();
    chk("mid_rst_valid",   64'(xif.out_valid_o), 64'(0));
    chk("mid_rst_pkt",     64'(x_pkt),           64'(0));
    chk("mid_rst_err_cnt", 64'(x_ecnt),          64'(0));
    chk("mid_rst_err",     64'(x_err),           64'(0));
    xif.out_ready_i = 1'b1;
    send(1'b0, 1'b0, 1'b1, mk(1, 1, 8'h61), 1'b0, LOCAL);
    chk("post_rst_idle_err", 64'(x_ecnt), 64'(1));
    send(1'b0, 1'b1, 1'b1, mk(2, 3, 8'h62), 1'b1, NORTH);
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_pkt",  64'(x_pkt),      64'(1));
    chk("x_sb_empty",    64'(xq.size()),  64'(0));
    chk("d_sb_empty",    64'(dq.size()),  64'(0));
    chk("d_err_cnt",     64'(d_ecnt),     64'(0));
    chk("d_err",         64'(d_err),      64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
